// File: rtl/seg_scan_2digit.sv
// -----------------------------------------------------------------------------
// seg_scan_2digit
//
// Two-digit multiplexed 7-segment display driver. It takes the tens and units
// segment patterns from the upstream counter and time-multiplexes them onto a
// shared segment bus with one anode enable per digit.
//
// The input patterns are captured once per frame into shadow registers, so a
// digit never tears mid-frame. Each digit slot starts with a short blanking
// guard that suppresses ghosting while the anodes switch. An optional
// leading-zero blank hides the tens digit when it shows "0".
//
// Ports
//   clock       system clock; all state on the rising edge
//   reset       asynchronous, active-low reset
//   enable      scan enable; low = display dark, scan frozen
//   digit1      tens pattern  {a,b,c,d,e,f,g}, 1 = segment lit
//   digit0      units pattern {a,b,c,d,e,f,g}, 1 = segment lit
//   seg         shared segment bus, polarity set by SEG_ACTIVE_LOW
//   an          anode enables, an[0] = units, an[1] = tens, polarity set by
//               AN_ACTIVE_LOW
//   slot        current slot state: 0 = units, 1 = tens
//   frame_tick  one-cycle pulse on the cycle after the shadows load
// -----------------------------------------------------------------------------
module seg_scan_2digit #(
    parameter int REFRESH_DIV    = 50000,  // clock cycles per digit slot, >= 2
    parameter int BLANK_CYCLES   = 16,     // guard cycles per slot, < REFRESH_DIV
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] digit1,
    input  logic [6:0] digit0,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       slot,
    output logic       frame_tick
);

    localparam int            CW         = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]    GLYPH_ZERO = 7'b1111110;

    // Inactive levels of the output buses. XOR-ing an active-high value into
    // these applies the configured polarity.
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] AN_OFF  = {2{AN_ACTIVE_LOW}};

    typedef enum logic {
        PH_GUARD = 1'b0,  // anodes and segments off
        PH_SHOW  = 1'b1   // current slot's anode on, its pattern on the bus
    } phase_t;

    // -------------------------------------------------------------------------
    // Slot counter and shadow capture
    // -------------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [6:0]    sh1;
    logic [6:0]    sh0;
    logic          slot_end;
    logic          capture;

    assign slot_end = (cnt == CNT_LAST);
    // Capture on the last cycle of the tens slot, i.e. at the frame boundary.
    // The capturing edge is also the slot toggle, so the fresh shadows are
    // first seen in the units slot after its guard phase.
    assign capture  = enable && slot_end && slot;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            slot       <= 1'b0;
            sh1        <= 7'b0;
            sh0        <= 7'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= capture;
            if (enable) begin
                if (slot_end) begin
                    cnt  <= '0;
                    slot <= ~slot;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (capture) begin
                sh1 <= digit1;
                sh0 <= digit0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-slot phase FSM. The state register also holds the slot and pattern
    // that go with the phase, so the output decode depends only on registers
    // and the bus lags cnt/slot by exactly one cycle.
    // -------------------------------------------------------------------------
    phase_t     phase;
    phase_t     phase_next;
    logic       disp_slot;
    logic [6:0] disp_pat;
    logic       in_guard;
    logic       lz_hide;

    assign in_guard = (int'(cnt) < BLANK_CYCLES);
    assign lz_hide  = LZ_BLANK && slot && (sh1 == GLYPH_ZERO);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase     <= PH_GUARD;
            disp_slot <= 1'b0;
            disp_pat  <= 7'b0;
        end else begin
            phase     <= phase_next;
            disp_slot <= slot;
            disp_pat  <= slot ? sh1 : sh0;
        end
    end

    // Next-state logic. A disabled scan and a hidden leading zero both look
    // exactly like the guard phase on the outputs.
    // NOTE: each combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        phase_next = PH_GUARD;
        if (enable && !in_guard && !lz_hide) begin
            phase_next = PH_SHOW;
        end
    end

    // Output decode. Only one anode bit can be flipped, so at most one digit
    // is ever driven.
    always_comb begin
        an  = AN_OFF;
        seg = SEG_OFF;
        if (phase == PH_SHOW) begin
            an  = AN_OFF ^ (disp_slot ? 2'b10 : 2'b01);
            seg = SEG_OFF ^ disp_pat;
        end
    end

endmodule

// File: tb/tb_seg_scan_2digit.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_2digit
//
// Self-checking bench for seg_scan_2digit with REFRESH_DIV = 8 and
// BLANK_CYCLES = 2. Two instances share the stimulus: one with leading-zero
// blanking, one without. The reference model counts enabled cycles since
// reset. The position inside the 16-cycle frame gives slot and slot
// offset; the shadow copies update at the frame boundary.
// -----------------------------------------------------------------------------
module tb_seg_scan_2digit;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 2 * RD;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [10:0] DARK = {2'b11, 7'h7F, 1'b0, 1'b0};

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] digit1 = 7'b0;
    logic [6:0] digit0 = 7'b0;

    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;
    logic       slot_a, slot_b, ft_a, ft_b;

    always #5 clock = ~clock;

    seg_scan_2digit #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b1)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .digit1(digit1), .digit0(digit0),
        .seg(seg_a), .an(an_a), .slot(slot_a), .frame_tick(ft_a)
    );

    seg_scan_2digit #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b0)) dut_nolz (
        .clock(clock), .reset(reset), .enable(enable),
        .digit1(digit1), .digit0(digit0),
        .seg(seg_b), .an(an_b), .slot(slot_b), .frame_tick(ft_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          n = 0;          // enabled cycles since reset release
    logic [6:0]  m_sh1 = 7'b0;
    logic [6:0]  m_sh0 = 7'b0;
    logic [10:0] exp_a = DARK;   // {an, seg, slot, frame_tick}
    logic [10:0] exp_b = DARK;

    // What the display shows for a given frame position, before the edge.
    function automatic logic [8:0] view(input bit lz, input int pos);
        bit tens;
        tens = (pos >= RD);
        if (!enable || (pos % RD) < BL) return {2'b11, 7'h7F};
        if (tens && lz && m_sh1 == G0) return {2'b11, 7'h7F};
        return {(tens ? 2'b01 : 2'b10), ~(tens ? m_sh1 : m_sh0)};
    endfunction

    // Advance one clock, update the model, return 1 time unit after the edge.
    task automatic cycle();
        int         pos;
        bit         cap;
        bit         tens_now;
        logic [8:0] va, vb;
        @(posedge clock);
        if (!reset) begin
            n     = 0;
            m_sh1 = 7'b0;
            m_sh0 = 7'b0;
            exp_a = DARK;
            exp_b = DARK;
        end else begin
            pos = n % FRAME;
            va  = view(1'b1, pos);
            vb  = view(1'b0, pos);
            cap = enable && (pos == FRAME - 1);
            if (cap) begin
                m_sh1 = digit1;
                m_sh0 = digit0;
            end
            if (enable) n++;
            tens_now = ((n % FRAME) >= RD);
            exp_a = {va, tens_now, cap};
            exp_b = {vb, tens_now, cap};
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            digit1 = 7'($urandom_range(0, 127));
            digit0 = 7'($urandom_range(0, 127));
            enable = 1'($urandom_range(0, 1));
            cycle();
            checks++;
            if ({an_a, seg_a, slot_a, ft_a} !== DARK) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, DARK);
            end
        end
    endtask

    task automatic test_basic();
        int ticks = 0;
        digit1 = G1;
        digit0 = G2;
        enable = 1'b1;
        reset  = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            if (ft_a === 1'b1) ticks++;
            checks += 2;
            if ({an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL basic_lz cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
            if ({an_b, seg_b, slot_b, ft_b} !== exp_b) begin
                errors++;
                $display("FAIL basic_nolz cyc %0d got %h want %h", i, {an_b, seg_b, slot_b, ft_b}, exp_b);
            end
            if (i == FRAME - 1) begin
                checks++;
                if (ft_a !== 1'b1) begin
                    errors++;
                    $display("FAIL first_tick got %b want 1", ft_a);
                end
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("FAIL tick_count got %0d want 3", ticks);
        end
    endtask

    task automatic test_lz();
        int tens_a = 0;
        int tens_b = 0;
        digit1 = G0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            if (i >= 2 * FRAME) begin
                if (an_a === 2'b01) tens_a++;
                if (an_b === 2'b01 && seg_b === 7'b0000001) tens_b++;
            end
            checks += 2;
            if ({an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL lz_on cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
            if ({an_b, seg_b, slot_b, ft_b} !== exp_b) begin
                errors++;
                $display("FAIL lz_off cyc %0d got %h want %h", i, {an_b, seg_b, slot_b, ft_b}, exp_b);
            end
        end
        checks += 2;
        if (tens_a != 0) begin
            errors++;
            $display("FAIL lz_tens_hidden got %0d want 0", tens_a);
        end
        if (tens_b != RD - BL) begin
            errors++;
            $display("FAIL lz_tens_shown got %0d want %0d", tens_b, RD - BL);
        end
    endtask

    task automatic test_mid_frame();
        digit1 = G1;
        digit0 = G2;
        for (int i = 0; i < 4 * FRAME; i++) begin
            cycle();
            // Change the units input part-way through a frame.
            if (i == FRAME + 5) digit0 = G3;
            checks += 2;
            if ({an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL mid_frame_lz cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
            if ({an_b, seg_b, slot_b, ft_b} !== exp_b) begin
                errors++;
                $display("FAIL mid_frame_nolz cyc %0d got %h want %h", i, {an_b, seg_b, slot_b, ft_b}, exp_b);
            end
        end
        checks++;
        if (m_sh0 !== G3) begin
            errors++;
            $display("FAIL mid_frame_model got %h want %h", m_sh0, G3);
        end
    endtask

    task automatic test_enable_gap();
        int guard = 0;
        int shows = 0;
        while ((n % FRAME) != 4 && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        checks++;
        if ((n % FRAME) != 4) begin
            errors++;
            $display("FAIL gap_align got %0d want 4", n % FRAME);
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({an_a, seg_a, slot_a, ft_a} !== {2'b11, 7'h7F, 1'b0, 1'b0} ||
                {an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL gap_dark cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < RD - 4; i++) begin
            cycle();
            if (an_a === 2'b10) shows++;
            checks++;
            if ({an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL gap_resume cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
        end
        checks += 2;
        if (shows != 4) begin
            errors++;
            $display("FAIL gap_show_cycles got %0d want 4", shows);
        end
        if (slot_a !== 1'b1) begin
            errors++;
            $display("FAIL gap_slot_toggle got %b want 1", slot_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30 * FRAME; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                digit1 = ($urandom_range(0, 2) == 0) ? G0 : 7'($urandom_range(0, 127));
                digit0 = 7'($urandom_range(0, 127));
            end
            enable = ($urandom_range(0, 9) != 0);
            cycle();
            checks += 3;
            if ({an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL random_lz cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
            if ({an_b, seg_b, slot_b, ft_b} !== exp_b) begin
                errors++;
                $display("FAIL random_nolz cyc %0d got %h want %h", i, {an_b, seg_b, slot_b, ft_b}, exp_b);
            end
            if (an_a === 2'b00 || an_b === 2'b00) begin
                errors++;
                $display("FAIL one_anode cyc %0d got %b/%b want at most one low", i, an_a, an_b);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        digit1 = G1;
        digit0 = G2;
        while (an_a === 2'b11 && guard < 3 * FRAME) begin
            cycle();
            guard++;
        end
        checks++;
        if (an_a === 2'b11) begin
            errors++;
            $display("FAIL async_setup got %b want an active", an_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({an_a, seg_a, slot_a, ft_a} !== DARK) begin
            errors++;
            $display("FAIL async_reset got %h want %h", {an_a, seg_a, slot_a, ft_a}, DARK);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({an_a, seg_a, slot_a, ft_a} !== DARK) begin
                errors++;
                $display("FAIL async_hold cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, DARK);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            cycle();
            checks++;
            if ({an_a, seg_a, slot_a, ft_a} !== exp_a) begin
                errors++;
                $display("FAIL async_restart cyc %0d got %h want %h", i, {an_a, seg_a, slot_a, ft_a}, exp_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_mid_frame();
        test_enable_gap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
